// File: rtl/Predef_pkg.sv
// rtl/Predef_pkg.sv - shared register-file typedefs and port-count limits
//
// Purpose: common types and constants for regfile_mp and its users.
// Contents:
//   REGFILE_WRITE_PORTS_MAX / REGFILE_READ_PORTS_MAX : supported port counts
//   REGFILE_XLEN_DEFAULT / REGFILE_REGS_DEFAULT      : default geometry
//   xlen_t, regfile_addr_t                           : default-geometry types
package Predef_pkg;

  localparam int REGFILE_WRITE_PORTS_MAX = 2;
  localparam int REGFILE_READ_PORTS_MAX  = 4;
  localparam int REGFILE_XLEN_DEFAULT    = 32;
  localparam int REGFILE_REGS_DEFAULT    = 32;

  typedef logic [REGFILE_XLEN_DEFAULT-1:0]          xlen_t;
  typedef logic [$clog2(REGFILE_REGS_DEFAULT)-1:0]  regfile_addr_t;

endpackage

// File: rtl/regfile_busy_sb.sv
// rtl/regfile_busy_sb.sv - per-register busy scoreboard for regfile_mp
//
// Purpose: holds one busy bit per register. Reservations set a bit, committed
// writes clear it, flush clears everything.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   clear_in [REGS]     : one-hot-per-register clears from accepted writes
//   reserve_in/_addr_in : mark one register busy
//   flush_in            : clear all busy bits (beats reserve)
//   read_addr_in        : READ_PORTS packed lookup addresses
//   read_busy_out       : registered busy bit per lookup port
module regfile_busy_sb
  import Predef_pkg::*;
#(
  parameter int REGS       = REGFILE_REGS_DEFAULT,
  parameter int AW         = $clog2(REGS),
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REGS-1:0]          clear_in,
  input  logic                     reserve_in,
  input  logic [AW-1:0]            reserve_addr_in,
  input  logic                     flush_in,
  input  logic [READ_PORTS*AW-1:0] read_addr_in,
  output logic [READ_PORTS-1:0]    read_busy_out
);

  logic [REGS-1:0] busy;
  logic [REGS-1:0] busy_next;

  // Reserve is applied after the write clears: it stands for a newer
  // producer, so it must win over a writeback to the same register.
  always_comb begin
    busy_next = busy & ~clear_in;
    if (reserve_in && !((ZERO_REG != 0) && (reserve_addr_in == '0))) begin
      busy_next[reserve_addr_in] = 1'b1;
    end
    if (flush_in) begin
      busy_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_comb begin
    read_busy_out = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      read_busy_out[r] = busy[read_addr_in[r*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with busy scoreboard
//
// Purpose: READ_PORTS combinational reads, WRITE_PORTS synchronous writes
// (highest port wins on same address), optional hardwired-zero r0, and a
// per-register busy bit for decode stalls.
// Optional feature: define REGFILE_MP_BYPASS_EN to forward same-cycle write
// data (and a cleared busy bit) to matching read ports.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   write_in          : per-port write enable
//   write_addr_in     : packed write addresses, port p at [p*AW +: AW]
//   write_data_in     : packed write data, port p at [p*XLEN +: XLEN]
//   read_addr_in      : packed read addresses
//   read_data_out     : packed read data
//   read_busy_out     : busy bit of each addressed register
//   reserve_in/_addr_in : mark one register busy
//   flush_in          : clear all busy bits
//   debugen_in        : trace enable, only meaningful in simulation models
module regfile_mp
  import Predef_pkg::*;
#(
  parameter int XLEN        = REGFILE_XLEN_DEFAULT,
  parameter int REGS        = REGFILE_REGS_DEFAULT,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int ZERO_REG    = 1,
  localparam int AW         = $clog2(REGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WRITE_PORTS-1:0]      write_in,
  input  logic [WRITE_PORTS*AW-1:0]   write_addr_in,
  input  logic [WRITE_PORTS*XLEN-1:0] write_data_in,
  input  logic [READ_PORTS*AW-1:0]    read_addr_in,
  output logic [READ_PORTS*XLEN-1:0]  read_data_out,
  output logic [READ_PORTS-1:0]       read_busy_out,
  input  logic                        reserve_in,
  input  logic [AW-1:0]               reserve_addr_in,
  input  logic                        flush_in,
  input  logic                        debugen_in
);

  // Port counts beyond what the priority/bypass muxing is built for are
  // clipped rather than silently growing the mux trees.
  localparam int WP = (WRITE_PORTS < REGFILE_WRITE_PORTS_MAX) ? WRITE_PORTS : REGFILE_WRITE_PORTS_MAX;
  localparam int RP = (READ_PORTS < REGFILE_READ_PORTS_MAX) ? READ_PORTS : REGFILE_READ_PORTS_MAX;

  logic [XLEN-1:0]       mem [REGS];
  logic [WRITE_PORTS-1:0] wr_ok;
  logic [REGS-1:0]       wr_clr;
  logic [READ_PORTS-1:0] sb_busy;

  // The per-cycle trace has no hardware counterpart.
  logic unused_debugen;
  assign unused_debugen = debugen_in;

  // A write to r0 is dropped entirely when r0 is hardwired to zero.
  always_comb begin
    wr_ok  = '0;
    wr_clr = '0;
    for (int p = 0; p < WP; p++) begin
      wr_ok[p] = write_in[p] &&
                 !((ZERO_REG != 0) && (write_addr_in[p*AW +: AW] == '0));
      if (wr_ok[p]) begin
        wr_clr[write_addr_in[p*AW +: AW]] = 1'b1;
      end
    end
  end

  // Ascending port order: the last (highest) port's assignment wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int p = 0; p < WP; p++) begin
        if (wr_ok[p]) begin
          mem[write_addr_in[p*AW +: AW]] <= write_data_in[p*XLEN +: XLEN];
        end
      end
    end
  end

  regfile_busy_sb #(
    .REGS       (REGS),
    .AW         (AW),
    .READ_PORTS (READ_PORTS),
    .ZERO_REG   (ZERO_REG)
  ) u_busy_sb (
    .clk             (clk),
    .reset           (reset),
    .clear_in        (wr_clr),
    .reserve_in      (reserve_in),
    .reserve_addr_in (reserve_addr_in),
    .flush_in        (flush_in),
    .read_addr_in    (read_addr_in),
    .read_busy_out   (sb_busy)
  );

  always_comb begin
    read_data_out = '0;
    read_busy_out = '0;
    for (int r = 0; r < RP; r++) begin
      read_data_out[r*XLEN +: XLEN] = mem[read_addr_in[r*AW +: AW]];
      read_busy_out[r]              = sb_busy[r];
`ifdef REGFILE_MP_BYPASS_EN
      for (int p = 0; p < WP; p++) begin
        if (wr_ok[p] && (write_addr_in[p*AW +: AW] == read_addr_in[r*AW +: AW])) begin
          read_data_out[r*XLEN +: XLEN] = write_data_in[p*XLEN +: XLEN];
          // A same-cycle reservation of this register is a newer producer.
          if (!(reserve_in && (reserve_addr_in == read_addr_in[r*AW +: AW]))) begin
            read_busy_out[r] = 1'b0;
          end
        end
      end
`endif
      if ((ZERO_REG != 0) && (read_addr_in[r*AW +: AW] == '0)) begin
        read_data_out[r*XLEN +: XLEN] = '0;
        read_busy_out[r]              = 1'b0;
      end
      // Forwarded write data must not leak out while the file is in reset.
      if (!reset) begin
        read_data_out[r*XLEN +: XLEN] = '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
module tb_regfile_mp;
  import Predef_pkg::*;

  localparam int XLEN = 32;
  localparam int REGS = 32;
  localparam int RP   = 2;
  localparam int WP   = 2;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [WP-1:0]     write_in;
  logic [WP*AW-1:0]  write_addr_in;
  logic [WP*XLEN-1:0] write_data_in;
  logic [RP*AW-1:0]  read_addr_in;
  logic [RP*XLEN-1:0] read_data_out;
  logic [RP-1:0]     read_busy_out;
  logic              reserve_in;
  logic [AW-1:0]     reserve_addr_in;
  logic              flush_in;
  logic              debugen_in;

  int checks   = 0;
  int failures = 0;

  xlen_t m_mem  [REGS];
  bit    m_busy [REGS];

  regfile_mp #(
    .XLEN        (XLEN),
    .REGS        (REGS),
    .READ_PORTS  (RP),
    .WRITE_PORTS (WP),
    .ZERO_REG    (1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .write_in        (write_in),
    .write_addr_in   (write_addr_in),
    .write_data_in   (write_data_in),
    .read_addr_in    (read_addr_in),
    .read_data_out   (read_data_out),
    .read_busy_out   (read_busy_out),
    .reserve_in      (reserve_in),
    .reserve_addr_in (reserve_addr_in),
    .flush_in        (flush_in),
    .debugen_in      (debugen_in)
  );

  always #5 clk = ~clk;

  function automatic xlen_t exp_data(input regfile_addr_t a);
    if (a == 0) return '0;
`ifdef REGFILE_MP_BYPASS_EN
    for (int p = WP - 1; p >= 0; p--) begin
      if (write_in[p] && write_addr_in[p*AW +: AW] == a) return write_data_in[p*XLEN +: XLEN];
    end
`endif
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input regfile_addr_t a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
    for (int p = 0; p < WP; p++) begin
      if (write_in[p] && write_addr_in[p*AW +: AW] == a && !(reserve_in && reserve_addr_in == a))
        return 1'b0;
    end
`endif
    return m_busy[a];
  endfunction

  task automatic idle();
    write_in   = '0;
    reserve_in = 1'b0;
    flush_in   = 1'b0;
  endtask

  task automatic set_rd(input regfile_addr_t a0, input regfile_addr_t a1);
    read_addr_in = {a1, a0};
  endtask

  task automatic set_wr(input int p, input regfile_addr_t a, input xlen_t d);
    write_in[p]                = 1'b1;
    write_addr_in[p*AW +: AW]  = a;
    write_data_in[p*XLEN +: XLEN] = d;
  endtask

  // One clock edge; the model takes the edge from the spec's rules.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      for (int p = 0; p < WP; p++) begin
        regfile_addr_t a;
        a = write_addr_in[p*AW +: AW];
        if (write_in[p] && a != 0) begin
          m_mem[a]  = write_data_in[p*XLEN +: XLEN];
          m_busy[a] = 1'b0;
        end
      end
      if (reserve_in && reserve_addr_in != 0) m_busy[reserve_addr_in] = 1'b1;
      if (flush_in) foreach (m_busy[i]) m_busy[i] = 1'b0;
    end
    #1;
  endtask

  task automatic model_clear();
    foreach (m_mem[i]) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      set_rd(regfile_addr_t'($urandom_range(0, 31)), regfile_addr_t'($urandom_range(0, 31)));
      #1;
      for (int r = 0; r < RP; r++) begin
        checks++;
        if (read_data_out[r*XLEN +: XLEN] !== 32'h0 || read_busy_out[r] !== 1'b0) begin
          failures++;
          $display("FAIL reset_state port%0d data=%h busy=%b required data=0 busy=0",
                   r, read_data_out[r*XLEN +: XLEN], read_busy_out[r]);
        end
      end
    end
    reset = 1'b1;
    idle();
    set_wr(0, 5'd5, 32'hDEADBEEF);
    reserve_in = 1'b1; reserve_addr_in = 5'd9;
    step();
    idle();
    set_rd(5'd5, 5'd9);
    #1;
    checks++;
    if (read_data_out[31:0] !== 32'hDEADBEEF || read_busy_out[1] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset r5=%h busy9=%b required DEADBEEF/1", read_data_out[31:0], read_busy_out[1]);
    end
    reset = 1'b0;
    model_clear();
    #1;
    for (int r = 0; r < RP; r++) begin
      checks++;
      if (read_data_out[r*XLEN +: XLEN] !== 32'h0 || read_busy_out[r] !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset port%0d data=%h busy=%b required 0/0",
                 r, read_data_out[r*XLEN +: XLEN], read_busy_out[r]);
      end
    end
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (read_data_out[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL post_reset r5=%h required 0", read_data_out[31:0]);
    end
  endtask

  task automatic test_dual_write();
    idle();
    set_wr(0, 5'd7, 32'h11111111);
    set_wr(1, 5'd7, 32'h22222222);
    step();
    idle();
    set_rd(5'd7, 5'd7);
    #1;
    for (int r = 0; r < RP; r++) begin
      checks++;
      if (read_data_out[r*XLEN +: XLEN] !== 32'h22222222 || read_busy_out[r] !== 1'b0) begin
        failures++;
        $display("FAIL dual_write port%0d data=%h busy=%b required 22222222/0",
                 r, read_data_out[r*XLEN +: XLEN], read_busy_out[r]);
      end
    end
  endtask

  task automatic test_zero_reg();
    idle();
    set_wr(1, 5'd0, 32'hFFFFFFFF);
    reserve_in = 1'b1; reserve_addr_in = 5'd0;
    set_rd(5'd0, 5'd0);
    #1;
    for (int r = 0; r < RP; r++) begin
      checks++;
      if (read_data_out[r*XLEN +: XLEN] !== 32'h0 || read_busy_out[r] !== 1'b0) begin
        failures++;
        $display("FAIL zero_reg_same_cycle port%0d data=%h busy=%b required 0/0",
                 r, read_data_out[r*XLEN +: XLEN], read_busy_out[r]);
      end
    end
    step();
    idle();
    #1;
    for (int r = 0; r < RP; r++) begin
      checks++;
      if (read_data_out[r*XLEN +: XLEN] !== 32'h0 || read_busy_out[r] !== 1'b0) begin
        failures++;
        $display("FAIL zero_reg port%0d data=%h busy=%b required 0/0",
                 r, read_data_out[r*XLEN +: XLEN], read_busy_out[r]);
      end
    end
  endtask

  task automatic test_scoreboard();
    idle();
    set_rd(5'd3, 5'd3);
    reserve_in = 1'b1; reserve_addr_in = 5'd3;
    step();
    idle();
    checks++;
    if (read_busy_out[0] !== 1'b1) begin
      failures++;
      $display("FAIL sb_reserve busy=%b required 1", read_busy_out[0]);
    end
    step();
    set_wr(0, 5'd3, 32'h5);
    #1;
    checks++;
    if (read_busy_out[1] !== exp_busy(5'd3) || read_data_out[63:32] !== exp_data(5'd3)) begin
      failures++;
      $display("FAIL sb_write_cycle busy=%b data=%h required %b/%h",
               read_busy_out[1], read_data_out[63:32], exp_busy(5'd3), exp_data(5'd3));
    end
    step();
    idle();
    #1;
    checks++;
    if (read_busy_out[0] !== 1'b0 || read_data_out[31:0] !== 32'h5) begin
      failures++;
      $display("FAIL sb_written busy=%b data=%h required 0/00000005", read_busy_out[0], read_data_out[31:0]);
    end
    set_wr(1, 5'd3, 32'h6);
    reserve_in = 1'b1; reserve_addr_in = 5'd3;
    step();
    idle();
    #1;
    checks++;
    if (read_busy_out[0] !== 1'b1 || read_data_out[31:0] !== 32'h6) begin
      failures++;
      $display("FAIL sb_reserve_and_write busy=%b data=%h required 1/00000006", read_busy_out[0], read_data_out[31:0]);
    end
  endtask

  task automatic test_flush();
    regfile_addr_t ra [3];
    ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd9;
    for (int k = 0; k < 3; k++) begin
      idle();
      reserve_in = 1'b1; reserve_addr_in = ra[k];
      step();
    end
    idle();
    set_rd(5'd1, 5'd9);
    #1;
    checks++;
    if (read_busy_out !== 2'b11) begin
      failures++;
      $display("FAIL flush_pre busy=%b required 11", read_busy_out);
    end
    flush_in = 1'b1;
    reserve_in = 1'b1; reserve_addr_in = 5'd4;
    step();
    idle();
    set_rd(5'd1, 5'd2);
    #1;
    checks++;
    if (read_busy_out !== 2'b00) begin
      failures++;
      $display("FAIL flush_r1_r2 busy=%b required 00", read_busy_out);
    end
    set_rd(5'd9, 5'd4);
    #1;
    checks++;
    if (read_busy_out !== 2'b00) begin
      failures++;
      $display("FAIL flush_r9_r4 busy=%b required 00", read_busy_out);
    end
  endtask

  task automatic test_bypass();
    idle();
    set_wr(0, 5'd8, 32'h00001234);
    step();
    idle();
    set_wr(0, 5'd8, 32'hCAFEF00D);
    set_rd(5'd8, 5'd8);
    #1;
    for (int r = 0; r < RP; r++) begin
      checks++;
      if (read_data_out[r*XLEN +: XLEN] !== exp_data(5'd8)) begin
        failures++;
        $display("FAIL bypass_same_cycle port%0d data=%h required %h",
                 r, read_data_out[r*XLEN +: XLEN], exp_data(5'd8));
      end
    end
    step();
    idle();
    #1;
    for (int r = 0; r < RP; r++) begin
      checks++;
      if (read_data_out[r*XLEN +: XLEN] !== 32'hCAFEF00D) begin
        failures++;
        $display("FAIL bypass_next_cycle port%0d data=%h required CAFEF00D",
                 r, read_data_out[r*XLEN +: XLEN]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      for (int p = 0; p < WP; p++) begin
        write_in[p] = ($urandom_range(0, 2) != 0);
        write_addr_in[p*AW +: AW] = regfile_addr_t'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
        write_data_in[p*XLEN +: XLEN] = $urandom;
      end
      reserve_in      = ($urandom_range(0, 2) == 0);
      reserve_addr_in = regfile_addr_t'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
      flush_in        = ($urandom_range(0, 15) == 0);
      set_rd(regfile_addr_t'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31)),
             regfile_addr_t'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31)));
      #1;
      for (int r = 0; r < RP; r++) begin
        regfile_addr_t a;
        a = read_addr_in[r*AW +: AW];
        checks++;
        if (read_data_out[r*XLEN +: XLEN] !== exp_data(a) || read_busy_out[r] !== exp_busy(a)) begin
          failures++;
          $display("FAIL random n=%0d port%0d addr=%0d data=%h busy=%b required %h/%b",
                   n, r, a, read_data_out[r*XLEN +: XLEN], read_busy_out[r], exp_data(a), exp_busy(a));
        end
      end
      step();
    end
    idle();
  endtask

  initial begin
    reset = 1'b0;
    debugen_in = 1'b0;
    write_addr_in = '0;
    write_data_in = '0;
    read_addr_in = '0;
    reserve_addr_in = '0;
    idle();
    model_clear();
    #12;
    test_reset();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_flush();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a built-in busy scoreboard, successor to the single-write/dual-read file in the tribe core. It provides READ_PORTS combinational read ports and WRITE_PORTS write ports, with deterministic same-address write priority and an optional hardwired-zero register. A per-register busy bit lets decode stall on pending writebacks. It sits between decode (reads, reservations) and writeback (writes).

## Interface
- XLEN, 32: register width in bits
- REGS, 32: register count, power of two ≥ 2; AW = $clog2(REGS)
- READ_PORTS, 2: read port count, 1..4
- WRITE_PORTS, 2: write port count, 1..2
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes, never busy

- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- write_in  input  WRITE_PORTS  per-port write enable
- write_addr_in  input  WRITE_PORTS*AW  write addresses, port p at [p*AW +: AW]
- write_data_in  input  WRITE_PORTS*XLEN  write data, port p at [p*XLEN +: XLEN]
- read_addr_in  input  READ_PORTS*AW  read addresses
- read_data_out  output  READ_PORTS*XLEN  read data
- read_busy_out  output  READ_PORTS  busy bit of addressed register
- reserve_in  input  1  mark reserve_addr_in busy
- reserve_addr_in  input  AW  register to reserve
- flush_in  input  1  clear all busy bits
- debugen_in  input  1  per-cycle $write trace of all port activity (simulation only)

## Operation
- Storage: REGS x XLEN array. Busy: REGS-bit vector.
- Write: at edge, each port p with write_in[p] stores its data and clears busy[addr].
- Two write ports, same address, both enabled: port WRITE_PORTS-1 wins. Busy is cleared.
- ZERO_REG=1, address 0: writes and reservations dropped; reads return 0, busy 0.
- Reserve: at edge, busy[reserve_addr_in] ← 1. Reserve and write to the same address in the same cycle: busy ends 1; reserve models a newer producer. Data is still written.
- flush_in: at edge, busy ← 0. It overrides reserve in the same cycle. Data writes in that cycle still occur.
- Read: read_data_out[r] = array[read_addr_in[r]], combinational. read_busy_out[r] = busy[read_addr_in[r]] as registered.
- Addresses ≥ REGS are impossible by construction (power-of-two REGS).

## Timing
- Reset asserted (async): array ← 0, busy ← 0. All read_data_out = 0 and read_busy_out = 0 while in reset.
- Reset deassertion is synchronised externally. The first edge after release performs normal writes.
- Read latency 0 with respect to read_addr_in. Written data is visible on the cycle after the write edge, unless bypass is on.
- Reserve is visible on read_busy_out the cycle after reserve_in.
- No handshake: every enable acts on the edge on which it is sampled high.

## Configuration
- REGFILE_MP_BYPASS_EN defined: in-cycle forwarding.
  - A read matching an enabled write address returns that write_data_in (highest winning port) in the same cycle.
  - read_busy_out for that port reads 0, unless reserve_in targets the same address in that cycle.
  - ZERO_REG still forces 0.
- Not defined: reads return array contents only. Write-to-read latency is 1 cycle.

## Structure
- Shared package Predef_pkg holds the regfile_addr_t / xlen_t typedefs and the REGFILE_WRITE_PORTS_MAX = 2 and REGFILE_READ_PORTS_MAX = 4 constants.
- One natural sub-module, regfile_busy_sb: busy vector, reserve/clear/flush logic, per-port busy lookup.
- Write-priority and bypass muxing stay in the top.

## Test plan
- Reset mid-operation: write 0xDEADBEEF to r5, then drop reset for one cycle -> read r5 = 0, busy r5 = 0 immediately.
- Dual write conflict: port0 writes r7=0x11111111, port1 writes r7=0x22222222 on the same edge -> next cycle r7 reads 0x22222222.
- Zero register: write r0=0xFFFFFFFF and reserve r0 -> r0 reads 0, busy 0 on all ports.
- Scoreboard: reserve r3 at cycle n -> busy=1 from n+1. Write r3=0x5 at n+2 -> busy=0 and data 0x5 from n+3. Reserve and write r3 together -> busy stays 1.
- Flush: reserve r1, r2, r9, then flush_in plus reserve r4 on the same edge -> all busy bits 0 next cycle.
- Bypass (macro on): write r8=0xCAFEF00D and read r8 on two ports in the same cycle -> both 0xCAFEF00D same cycle. Macro off -> old value, then new value next cycle.
